ni_vc_inject_sched: RTL
=======================

Name: ni_vc_inject_sched

Overview:
Per-tile injection scheduler between a tile's packet sources (one queue per virtual channel) and the NoC local port (flit_out / flit_out_wr / credit_in).
- Keeps a credit counter per VC, mirroring the router input buffer depth B.
- Picks one eligible VC per cycle, round-robin, and assembles the NoC flit (header/tail bits, one-hot VC, payload).
- Drives the flit onto the NoC port through one register stage.
- Checks packet framing per VC and reports credit/protocol errors.

Parameters:
V, 2, number of virtual channels (≥1)
B, 4, router input buffer depth per VC, in flits; initial and maximum credit
Fpay, 32, flit payload width
Fw (localparam), 2+V+Fpay, NoC flit width
CRw (localparam), log2(B+1), credit counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
inject_en  in  1  when low, no new grants are issued; credits still tracked
req_valid  in  V  VC v has a flit pending
req_hdr  in  V  pending flit on VC v is a header
req_tail  in  V  pending flit on VC v is a tail
req_payload  in  V*Fpay  payload for VC v, in slice [(v+1)*Fpay-1 : v*Fpay]
req_ready  out  V  one-hot pop strobe; the flit is consumed this cycle
flit_out  out  Fw  to NoC local port
flit_out_wr  out  1  flit_out valid
credit_in  in  V  credit return from router, one per freed buffer slot
credit_avail  out  V  credit counter of VC v is > 0
vc_active  out  V  VC v is inside a packet (header sent, tail not yet sent)
err_credit  out  1  sticky: credit returned while counter == B
err_proto  out  1  sticky: framing violation
err_clr  in  1  synchronous clear of both sticky errors

Behaviour:
- Reset values:
  - credit[v] = B, pointer = 0, vc_active = 0.
  - flit_out = 0, flit_out_wr = 0, err_* = 0.
  - req_ready = 0; it is combinational and is 0 while reset is asserted.
- Eligibility: elig[v] = inject_en & req_valid[v] & (credit[v] != 0).
- Arbitration:
  - Round-robin search starting at pointer; at most one grant per cycle.
  - req_ready = grant, combinational in the same cycle as valid.
  - After granting v, pointer <= (v+1) mod V. With no grant, pointer holds.
- Output register: on the edge after grant v:
  - flit_out_wr = 1.
  - flit_out = {hdr, tail, onehot(v), payload_v}, with bit Fw-1 = hdr, bit Fw-2 = tail, bits [Fpay+V-1:Fpay] = VC one-hot.
  - With no grant, flit_out_wr = 0 and flit_out holds its last value.
  - Latency from grant to flit_out_wr is 1 cycle.
- Credits, per VC per cycle:
  - Grant without credit_in: credit decrements by 1.
  - credit_in without grant: credit increments by 1.
  - Both in the same cycle: credit is unchanged.
  - credit_in while credit == B with no grant: counter saturates at B and err_credit is set.
  - The counter never underflows, because a grant requires credit != 0.
- Framing FSM per VC, states IDLE and ACTIVE (vc_active = state == ACTIVE):
  - IDLE, granted header, tail = 0: go to ACTIVE.
  - IDLE, granted header with tail = 1 (single-flit packet): stay IDLE.
  - IDLE, granted non-header: flit is popped but NOT sent (no flit_out_wr, no credit consumed); err_proto is set.
  - ACTIVE, granted tail: go to IDLE.
  - ACTIVE, granted header: flit is sent; err_proto is set. Next state is IDLE if tail = 1, otherwise ACTIVE.
- Sticky errors:
  - err_clr clears both sticky errors.
  - If err_clr and a new error event occur in the same cycle, the error event wins (bit stays 1).
- inject_en deassertion mid-packet: pending flits stall; FSM state and credits are retained.
- Asynchronous reset mid-packet: all state returns to reset values immediately. In-flight router credits are not reconciled; the system resets the NoC together with this block.

Decomposition:
- Shared package (ni_sched_pkg):
  - log2 function.
  - Flit field position constants: HDR_BIT, TAIL_BIT, VC_LSB, payload range, all derived from V and Fpay.
  - FSM state encoding: IDLE = 1'b0, ACTIVE = 1'b1.
- One sub-module: rr_vc_arbiter.
  - Parameter N.
  - Inputs: request vector, pointer. Output: one-hot grant.
  - Purely combinational.
  - Pointer register lives in the parent.

Test Plan (V=2, B=4, Fpay=32):
1. Reset, then VC0 sends header / body / tail with no credit_in → three flit_out_wr pulses, one cycle after each req_ready; credit[0] goes 4→1; vc_active[0] goes 1, then 0 after the tail; flit_out[33:32] = 2'b01.
2. Both VCs stream continuously with credit_in pulsed on every flit → grants alternate VC0, VC1, VC0, …; one flit per cycle; credits remain 4.
3. VC1 sends 4 flits with no credit_in → credit_avail[1] = 0 and a 5th pending flit stalls. One credit_in[1] pulse → that flit is granted on the next cycle.
4. Grant and credit_in on VC0 in the same cycle at credit = 2 → credit stays 2. credit_in[0] at credit = 4 with no grant → credit stays 4 and err_credit = 1. err_clr → err_credit = 0.
5. VC0 idle presents a body flit → req_ready[0] = 1, flit_out_wr stays 0, err_proto = 1, credit unchanged. Header with tail = 1 → single flit sent, vc_active[0] remains 0.
6. Assert reset mid-packet on VC1 with credit = 1 → immediately vc_active = 0, flit_out_wr = 0, credits = 4, pointer = 0. After release, the first grant goes to VC0 when both VCs request.

Source files
------------

// File: rtl/ni_sched_pkg.sv
// ni_sched_pkg: shared helpers, flit field positions and framing FSM encoding for the injection scheduler.
package ni_sched_pkg;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} vc_state_e;
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int hdr_bit(input int v, input int fpay);
    return fpay + v + 1;
  endfunction
  function automatic int tail_bit(input int v, input int fpay);
    return fpay + v;
  endfunction
  function automatic int vc_lsb(input int fpay);
    return fpay;
  endfunction
  function automatic int pay_msb(input int fpay);
    return fpay - 1;
  endfunction
  localparam int PAY_LSB = 0;
endpackage

// File: rtl/ni_vc_inject_sched_rr_vc_arbiter.sv
// rr_vc_arbiter: combinational round-robin arbiter, one-hot grant to the first requester at or after ptr.
module rr_vc_arbiter
  import ni_sched_pkg::*;
#(
  parameter int N = 2,
  localparam int PW = (N > 1) ? log2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  int k;
  // Walk from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    grant = '0;
    k = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      if (req[k]) grant = N'(1) << k;
    end
  end
endmodule

// File: rtl/ni_vc_inject_sched.sv
// ni_vc_inject_sched: per-tile VC injection scheduler with credit tracking,
// round-robin VC selection, registered NoC flit output and per-VC framing checks.
module ni_vc_inject_sched
  import ni_sched_pkg::*;
#(
  parameter int V    = 2,
  parameter int B    = 4,
  parameter int Fpay = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inject_en,
  input  logic [V-1:0]        req_valid,
  input  logic [V-1:0]        req_hdr,
  input  logic [V-1:0]        req_tail,
  input  logic [V*Fpay-1:0]   req_payload,
  output logic [V-1:0]        req_ready,
  output logic [2+V+Fpay-1:0] flit_out,
  output logic                flit_out_wr,
  input  logic [V-1:0]        credit_in,
  output logic [V-1:0]        credit_avail,
  output logic [V-1:0]        vc_active,
  output logic                err_credit,
  output logic                err_proto,
  input  logic                err_clr
);
  localparam int Fw      = 2 + V + Fpay;
  localparam int CRw     = log2(B + 1);
  localparam int PW      = (V > 1) ? log2(V) : 1;
  localparam int HDR_BIT = hdr_bit(V, Fpay);
  localparam int TL_BIT  = tail_bit(V, Fpay);
  localparam int VC_LSB  = vc_lsb(Fpay);
  localparam int PAY_MSB = pay_msb(Fpay);
  logic [CRw-1:0] credit [V];
  vc_state_e      state_q [V];
  vc_state_e      state_d [V];
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  gidx;
  logic [V-1:0]   elig, grant, send, proto_ev, full;
  logic [Fw-1:0]  flit_d;
  rr_vc_arbiter #(.N(V)) u_arb (
    .req  (elig),
    .ptr  (ptr),
    .grant(grant)
  );
  assign req_ready = grant;
  // A granted non-header in IDLE is popped and discarded: no flit, no credit.
  always_comb begin
    gidx = '0;
    flit_d = '0;
    for (int v = 0; v < V; v++) begin
      elig[v] = ~reset & inject_en & req_valid[v] & (credit[v] != '0);
      full[v] = credit[v] == CRw'(B);
      credit_avail[v] = credit[v] != '0;
      vc_active[v] = state_q[v] == ACTIVE;
    end
    for (int v = 0; v < V; v++) begin
      send[v] = grant[v] & ((state_q[v] == ACTIVE) | req_hdr[v]);
      proto_ev[v] = grant[v] & ((state_q[v] == ACTIVE) ? req_hdr[v] : ~req_hdr[v]);
      state_d[v] = !grant[v] ? state_q[v] :
                   (state_q[v] == IDLE) ? ((req_hdr[v] & ~req_tail[v]) ? ACTIVE : IDLE) :
                   (req_tail[v] ? IDLE : ACTIVE);
      if (grant[v]) begin
        gidx = PW'(v);
        flit_d[HDR_BIT] = req_hdr[v];
        flit_d[TL_BIT] = req_tail[v];
        flit_d[VC_LSB +: V] = V'(1) << v;
        flit_d[PAY_MSB:PAY_LSB] = req_payload[v*Fpay +: Fpay];
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
      flit_out <= '0;
      flit_out_wr <= 1'b0;
      err_credit <= 1'b0;
      err_proto <= 1'b0;
      for (int v = 0; v < V; v++) begin
        credit[v] <= CRw'(B);
        state_q[v] <= IDLE;
      end
    end else begin
      flit_out_wr <= |send;
      if (|send) flit_out <= flit_d;
      if (|grant) ptr <= (gidx == PW'(V - 1)) ? '0 : gidx + 1'b1;
      err_credit <= (|(credit_in & ~send & full)) | (err_credit & ~err_clr);
      err_proto <= (|proto_ev) | (err_proto & ~err_clr);
      for (int v = 0; v < V; v++) begin
        state_q[v] <= state_d[v];
        if (send[v] & ~credit_in[v]) credit[v] <= credit[v] - 1'b1;
        else if (~send[v] & credit_in[v] & ~full[v]) credit[v] <= credit[v] + 1'b1;
      end
    end
  end
endmodule
